// File: rtl/sequencer_pkg.sv
// Shared symbols for the instruction sequencer.
//   state_t  : 8-bit state codes consumed by the control decoder
//   OPC_*    : instruction opcode field, instr[7:5]
//   SUB_*    : stack sub-operation field, instr[4:3]
//   JMP_*    : jump condition codes carried on operand2, instr[2:0]
package sequencer_pkg;

    typedef enum logic [7:0] {
        STATE_FETCH_PC   = 8'h00,
        STATE_FETCH_INST = 8'h01,
        STATE_ALU_EXEC   = 8'h02,
        STATE_ALU_OUT    = 8'h03,
        STATE_MOV_REG    = 8'h04,
        STATE_SET_REG    = 8'h05,
        STATE_LOAD_ADDR  = 8'h06,
        STATE_SET_MEM    = 8'h07,
        STATE_JUMP       = 8'h08,
        STATE_FETCH_SP   = 8'h09,
        STATE_STACK_REG  = 8'h0A,
        STATE_TMP_JUMP   = 8'h0B,
        STATE_INC_SP     = 8'h0C,
        STATE_RET        = 8'h0D,
        STATE_HALT       = 8'h0E
    } state_t;

    localparam logic [2:0] OPC_ALU = 3'd0;
    localparam logic [2:0] OPC_MOV = 3'd1;
    localparam logic [2:0] OPC_LDI = 3'd2;
    localparam logic [2:0] OPC_LD  = 3'd3;
    localparam logic [2:0] OPC_ST  = 3'd4;
    localparam logic [2:0] OPC_JMP = 3'd5;
    localparam logic [2:0] OPC_STK = 3'd6;
    localparam logic [2:0] OPC_HLT = 3'd7;

    localparam logic [1:0] SUB_PUSH = 2'd0;
    localparam logic [1:0] SUB_CALL = 2'd1;
    localparam logic [1:0] SUB_RET  = 2'd2;

    // Jump conditions are evaluated by the decoder; listed here so both
    // sides agree on the operand2 encoding.
    localparam logic [2:0] JMP_ALWAYS = 3'd0;
    localparam logic [2:0] JMP_ZERO   = 3'd1;
    localparam logic [2:0] JMP_NZERO  = 3'd2;
    localparam logic [2:0] JMP_CARRY  = 3'd3;
    localparam logic [2:0] JMP_NCARRY = 3'd4;

endpackage

// File: rtl/sequencer_rom.sv
// seq_rom: combinational micro-step table.
//   opc, sub   : instruction fields (live from the bus during FETCH_INST)
//   step       : index of the micro-step being looked up
//   next_state : state code for that step
//   last       : that step is the final one of the instruction
//   bad        : undefined sub-operation (only STK sub 11)
// Steps 0/1 are always FETCH_PC/FETCH_INST; the tail starts at step 2.
module seq_rom
    import sequencer_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic [2:0]        opc,
    input  logic [1:0]        sub,
    input  logic [STEP_W-1:0] step,
    output state_t            next_state,
    output logic              last,
    output logic              bad
);

    int t;

    always_comb begin
        next_state = STATE_FETCH_PC;
        last       = 1'b1;
        bad        = 1'b0;
        t          = int'(step) - 2;
        if (step == STEP_W'(0)) begin
            last = 1'b0;
        end else if (step == STEP_W'(1)) begin
            next_state = STATE_FETCH_INST;
            last       = 1'b0;
        end else begin
            // Out-of-range tail indices fall through to FETCH_PC/last.
            case (opc)
                OPC_ALU: case (t)
                    0: begin next_state = STATE_ALU_EXEC; last = 1'b0; end
                    1: next_state = STATE_ALU_OUT;
                    default: ;
                endcase
                OPC_MOV: if (t == 0) next_state = STATE_MOV_REG;
                OPC_LDI: case (t)
                    0: last = 1'b0;
                    1: next_state = STATE_SET_REG;
                    default: ;
                endcase
                OPC_LD, OPC_ST: case (t)
                    0: last = 1'b0;
                    1: begin next_state = STATE_LOAD_ADDR; last = 1'b0; end
                    2: next_state = (opc == OPC_LD) ? STATE_SET_REG : STATE_SET_MEM;
                    default: ;
                endcase
                OPC_JMP: case (t)
                    0: last = 1'b0;
                    1: next_state = STATE_JUMP;
                    default: ;
                endcase
                OPC_STK: case (sub)
                    SUB_PUSH: case (t)
                        0: begin next_state = STATE_FETCH_SP; last = 1'b0; end
                        1: next_state = STATE_STACK_REG;
                        default: ;
                    endcase
                    SUB_CALL: case (t)
                        0: last = 1'b0;
                        1: begin next_state = STATE_FETCH_SP; last = 1'b0; end
                        2: next_state = STATE_TMP_JUMP;
                        default: ;
                    endcase
                    SUB_RET: case (t)
                        0: begin next_state = STATE_FETCH_SP; last = 1'b0; end
                        1: begin next_state = STATE_INC_SP; last = 1'b0; end
                        2: next_state = STATE_RET;
                        default: ;
                    endcase
                    default: bad = 1'b1;
                endcase
                default: if (t == 0) next_state = STATE_HALT;
            endcase
        end
    end

endmodule

// File: rtl/sequencer.sv
// sequencer: walks the per-opcode micro-step table and drives the decoder.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : advance enable; low freezes every register
//   bus        : data bus, instruction byte sampled while in FETCH_INST
//   state      : current state code (registered)
//   operand2   : latched instr[2:0], jump condition for JUMP
//   instr_done : high during the last step of each instruction
//   illegal    : sticky undefined-sub-op flag, cleared only by reset
module sequencer
    import sequencer_pkg::*;
#(
    parameter int MAX_STEPS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] bus,
    output logic [7:0] state,
    output logic [2:0] operand2,
    output logic       instr_done,
    output logic       illegal
);

    localparam int STEP_W = $clog2(MAX_STEPS);

    state_t            state_reg;
    logic [STEP_W-1:0] step_reg;
    logic [2:0]        opc_reg;
    logic [1:0]        sub_reg;
    logic [2:0]        operand2_reg;
    logic              done_reg;
    logic              illegal_reg;

    logic              fetching;
    logic              step_sat;
    logic [2:0]        opc_eff;
    logic [1:0]        sub_eff;
    logic [STEP_W-1:0] step_next;
    state_t            rom_state;
    logic              rom_last;
    logic              rom_bad;

    // During FETCH_INST the opcode is not latched yet, so the table is
    // addressed straight from the bus for the first tail step.
    assign fetching  = (step_reg == STEP_W'(1));
    assign step_sat  = (step_reg == STEP_W'(MAX_STEPS - 1));
    assign opc_eff   = fetching ? bus[7:5] : opc_reg;
    assign sub_eff   = fetching ? bus[4:3] : sub_reg;
    assign step_next = step_reg + STEP_W'(1);

    seq_rom #(.STEP_W(STEP_W)) u_rom (
        .opc        (opc_eff),
        .sub        (sub_eff),
        .step       (step_next),
        .next_state (rom_state),
        .last       (rom_last),
        .bad        (rom_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= STATE_FETCH_PC;
            step_reg     <= '0;
            opc_reg      <= '0;
            sub_reg      <= '0;
            operand2_reg <= '0;
            done_reg     <= 1'b0;
            illegal_reg  <= 1'b0;
        end else if (en) begin
            if (fetching) begin
                opc_reg      <= bus[7:5];
                sub_reg      <= bus[4:3];
                operand2_reg <= bus[2:0];
            end
            if (state_reg == STATE_HALT) begin
                // HALT code is unique, so it can safely gate: absorb until reset.
                done_reg <= 1'b0;
            end else if (done_reg || step_sat) begin
                state_reg <= STATE_FETCH_PC;
                step_reg  <= '0;
                done_reg  <= 1'b0;
            end else if (rom_bad) begin
                state_reg   <= STATE_FETCH_PC;
                step_reg    <= '0;
                done_reg    <= 1'b0;
                illegal_reg <= 1'b1;
            end else begin
                state_reg <= rom_state;
                step_reg  <= step_next;
                done_reg  <= rom_last;
            end
        end
    end

    assign state      = state_reg;
    assign operand2   = operand2_reg;
    assign instr_done = done_reg;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_sequencer.sv
module tb_sequencer;
    import sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] bus;
    logic [7:0] state;
    logic [2:0] operand2;
    logic       instr_done;
    logic       illegal;

    always #5 clk = ~clk;

    sequencer #(.MAX_STEPS(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bus        (bus),
        .state      (state),
        .operand2   (operand2),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: an instruction is a list of states (FETCH_PC,
    // FETCH_INST, tail...); m_pos indexes into that list.
    logic [7:0] prog[$];
    logic [7:0] m_byte;
    int         m_pos;
    bit         m_halted;
    bit         m_ill;
    logic [2:0] m_op2;
    logic [7:0] exp_state;
    logic       exp_done;

    function automatic int tail_len(input logic [7:0] b);
        case (b[7:5])
            3'd0: return 2;
            3'd1: return 1;
            3'd2: return 2;
            3'd3: return 3;
            3'd4: return 3;
            3'd5: return 2;
            3'd6: case (b[4:3])
                2'd0: return 2;
                2'd1: return 3;
                2'd2: return 3;
                default: return 0;
            endcase
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] tail_state(input logic [7:0] b, input int i);
        state_t t[3];
        t = '{STATE_FETCH_PC, STATE_FETCH_PC, STATE_FETCH_PC};
        case (b[7:5])
            3'd0: t = '{STATE_ALU_EXEC, STATE_ALU_OUT, STATE_FETCH_PC};
            3'd1: t = '{STATE_MOV_REG, STATE_FETCH_PC, STATE_FETCH_PC};
            3'd2: t = '{STATE_FETCH_PC, STATE_SET_REG, STATE_FETCH_PC};
            3'd3: t = '{STATE_FETCH_PC, STATE_LOAD_ADDR, STATE_SET_REG};
            3'd4: t = '{STATE_FETCH_PC, STATE_LOAD_ADDR, STATE_SET_MEM};
            3'd5: t = '{STATE_FETCH_PC, STATE_JUMP, STATE_FETCH_PC};
            3'd6: case (b[4:3])
                2'd0: t = '{STATE_FETCH_SP, STATE_STACK_REG, STATE_FETCH_PC};
                2'd1: t = '{STATE_FETCH_PC, STATE_FETCH_SP, STATE_TMP_JUMP};
                2'd2: t = '{STATE_FETCH_SP, STATE_INC_SP, STATE_RET};
                default: ;
            endcase
            default: t = '{STATE_HALT, STATE_FETCH_PC, STATE_FETCH_PC};
        endcase
        return t[i[1:0]];
    endfunction

    function automatic logic [7:0] next_byte();
        logic [7:0] b;
        if (prog.size() > 0) return prog.pop_front();
        do b = 8'($urandom); while (b[7:5] == 3'd7);
        return b;
    endfunction

    task automatic model_outputs();
        if (m_halted) begin
            exp_state = STATE_HALT;
            exp_done  = 1'b0;
        end else begin
            if (m_pos == 0)      exp_state = STATE_FETCH_PC;
            else if (m_pos == 1) exp_state = STATE_FETCH_INST;
            else                 exp_state = tail_state(m_byte, m_pos - 2);
            exp_done = (m_pos >= 2) && (m_pos == 1 + tail_len(m_byte));
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_halted = 0; m_ill = 0; m_op2 = 3'd0;
        model_outputs();
    endtask

    task automatic model_advance(input logic e);
        if (e && !m_halted) begin
            if (m_pos == 0) begin
                m_byte = next_byte();
                m_pos  = 1;
            end else if (m_pos == 1) begin
                m_op2 = m_byte[2:0];
                if (tail_len(m_byte) == 0) begin
                    m_ill = 1;
                    m_pos = 0;
                end else begin
                    m_pos = 2;
                end
            end else if (m_pos == 1 + tail_len(m_byte)) begin
                if (m_byte[7:5] == 3'd7) m_halted = 1;
                else                     m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        model_outputs();
    endtask

    // One clock: drive inputs, advance the model on the edge, return at negedge.
    task automatic tick(input logic e);
        en  = e;
        bus = (m_pos == 1) ? m_byte : 8'($urandom);
        @(posedge clk);
        model_advance(e);
        @(negedge clk);
    endtask

    task automatic assert_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit reached;
        rst_n = 1'b0; en = 1'b0; bus = 8'h00;
        model_reset();
        #2;
        vectors++;
        if (state !== STATE_FETCH_PC || instr_done !== 1'b0 || illegal !== 1'b0 || operand2 !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_init: state=%h done=%b ill=%b op2=%0d, expected 00 0 0 0", state, instr_done, illegal, operand2);
        end
        release_reset();
        prog.push_back(8'h60);
        reached = 0;
        for (int i = 0; i < 8 && !reached; i++) begin
            tick(1'b1);
            reached = (state === STATE_LOAD_ADDR);
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL reset_reach_ld: state=%h, expected LOAD_ADDR %h within 8 clk", state, STATE_LOAD_ADDR);
        end
        assert_reset();
        vectors++;
        if (state !== STATE_FETCH_PC || instr_done !== 1'b0 || illegal !== 1'b0 || operand2 !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mid_ld: state=%h done=%b ill=%b op2=%0d, expected 00 0 0 0", state, instr_done, illegal, operand2);
        end
        release_reset();
        $display("test_reset done");
    endtask

    task automatic test_alu();
        logic [7:0] seq[4];
        seq = '{STATE_FETCH_INST, STATE_ALU_EXEC, STATE_ALU_OUT, STATE_FETCH_PC};
        prog.push_back(8'h05);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            vectors++;
            if (state !== seq[i] || instr_done !== (i == 2) || state !== exp_state || operand2 !== m_op2 || illegal !== m_ill) begin
                miscompares++;
                $display("FAIL alu cyc%0d: state=%h done=%b op2=%0d ill=%b, expected state=%h done=%b op2=%0d ill=%b",
                         i, state, instr_done, operand2, illegal, seq[i], (i == 2), m_op2, m_ill);
            end
        end
        vectors++;
        if (operand2 !== 3'b101) begin
            miscompares++;
            $display("FAIL alu_operand2: got %b expected 101", operand2);
        end
        $display("test_alu done");
    endtask

    task automatic test_ld_stall();
        logic       ens[7];
        logic [7:0] seq[7];
        int         la_cycles;
        ens = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        seq = '{STATE_FETCH_INST, STATE_FETCH_PC, STATE_LOAD_ADDR, STATE_LOAD_ADDR,
                STATE_LOAD_ADDR, STATE_SET_REG, STATE_FETCH_PC};
        la_cycles = 0;
        prog.push_back(8'h60);
        for (int i = 0; i < 7; i++) begin
            tick(ens[i]);
            if (state === STATE_LOAD_ADDR) la_cycles++;
            vectors++;
            if (state !== seq[i] || state !== exp_state || instr_done !== exp_done || instr_done !== (i == 5)) begin
                miscompares++;
                $display("FAIL ld_stall cyc%0d: state=%h done=%b, expected state=%h done=%b", i, state, instr_done, seq[i], (i == 5));
            end
        end
        vectors++;
        if (la_cycles != 3) begin
            miscompares++;
            $display("FAIL ld_stall_hold: LOAD_ADDR cycles=%0d expected 3", la_cycles);
        end
        $display("test_ld_stall done");
    endtask

    task automatic test_call_ret();
        logic [7:0] seq[10];
        seq = '{STATE_FETCH_INST, STATE_FETCH_PC, STATE_FETCH_SP, STATE_TMP_JUMP, STATE_FETCH_PC,
                STATE_FETCH_INST, STATE_FETCH_SP, STATE_INC_SP, STATE_RET, STATE_FETCH_PC};
        prog.push_back(8'hC8);
        prog.push_back(8'hD0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            vectors++;
            if (state !== seq[i] || state !== exp_state || instr_done !== exp_done || illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL call_ret cyc%0d: state=%h done=%b ill=%b, expected state=%h done=%b ill=0",
                         i, state, instr_done, illegal, seq[i], exp_done);
            end
        end
        $display("test_call_ret done");
    endtask

    task automatic test_illegal();
        logic [7:0] seq[6];
        seq = '{STATE_FETCH_INST, STATE_FETCH_PC, STATE_FETCH_INST, STATE_ALU_EXEC, STATE_ALU_OUT, STATE_FETCH_PC};
        prog.push_back(8'hD8);
        prog.push_back(8'h05);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            vectors++;
            if (state !== seq[i] || illegal !== (i >= 1) || instr_done !== exp_done || instr_done !== (i == 4)) begin
                miscompares++;
                $display("FAIL illegal cyc%0d: state=%h ill=%b done=%b, expected state=%h ill=%b done=%b",
                         i, state, illegal, instr_done, seq[i], (i >= 1), (i == 4));
            end
        end
        $display("test_illegal done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0);
            vectors++;
            if (state !== exp_state || instr_done !== exp_done || operand2 !== m_op2 || illegal !== m_ill) begin
                miscompares++;
                $display("FAIL random cyc%0d: state=%h done=%b op2=%0d ill=%b, expected state=%h done=%b op2=%0d ill=%b",
                         i, state, instr_done, operand2, illegal, exp_state, exp_done, m_op2, m_ill);
            end
        end
        $display("test_random done");
    endtask

    task automatic test_halt();
        int pulses;
        assert_reset();
        release_reset();
        pulses = 0;
        prog.push_back(8'hE0);
        for (int i = 0; i < 26; i++) begin
            tick(1'b1);
            if (instr_done === 1'b1) pulses++;
            vectors++;
            if (state !== exp_state || instr_done !== exp_done || (i >= 2 && state !== STATE_HALT)) begin
                miscompares++;
                $display("FAIL halt cyc%0d: state=%h done=%b, expected state=%h done=%b", i, state, instr_done, exp_state, exp_done);
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL halt_pulse: instr_done cycles=%0d expected 1", pulses);
        end
        assert_reset();
        vectors++;
        if (state !== STATE_FETCH_PC || instr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_reset: state=%h done=%b expected 00 0", state, instr_done);
        end
        release_reset();
        prog.push_back(8'h20);
        tick(1'b1);
        vectors++;
        if (state !== STATE_FETCH_INST) begin
            miscompares++;
            $display("FAIL halt_restart: state=%h expected %h", state, STATE_FETCH_INST);
        end
        $display("test_halt done");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ld_stall();
        test_call_ret();
        test_illegal();
        test_random();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
